// File: rtl/pulse_stretch_pkg.sv
// Shared types and arbitration helpers for the pulse-stretch scheduler.
// fp_pick is only used when PULSE_STRETCH_SCHED_FIXED_PRIO_EN is defined.
package pulse_stretch_pkg;

    localparam int DELAY_W_DEF = 4;
    localparam int MAX_REQ     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } sched_state_e;

    // Round-robin winner: first pending index after ptr, wrapping. Scans farthest
    // to nearest so the nearest pending index is the last one written.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] pending, input int ptr,
                                   input int n_req);
        int win;
        int idx;
        win = ptr;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n_req) begin
                idx = ptr + k;
                if (idx >= n_req) begin
                    idx = idx - n_req;
                end
                if (pending[idx[2:0]]) begin
                    win = idx;
                end
            end
        end
        return win;
    endfunction

    function automatic int fp_pick(input logic [MAX_REQ-1:0] pending, input int n_req);
        int win;
        win = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n_req && pending[i]) begin
                win = i;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/pulse_stretch_cnt.sv
// Pulse length counter: loads max(delay,1), counts down while enabled and
// flags the final cycle of the pulse.
module pulse_stretch_cnt
    import pulse_stretch_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [DELAY_W-1:0] delay_i,
    output logic               last_o
);

    logic [DELAY_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (delay_i == '0) ? DELAY_W'(1) : delay_i;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - DELAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == DELAY_W'(1));

endmodule

// File: rtl/pulse_stretch_sched.sv
// Shares one stretched-pulse output between N_REQ requesters, round-robin by default.
// Define PULSE_STRETCH_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module pulse_stretch_sched
    import pulse_stretch_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DELAY_W    = DELAY_W_DEF,
    parameter int GAP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*DELAY_W-1:0]   delay_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic [N_REQ-1:0]           done_o,
    output logic                       pulse_out,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_e       state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [DELAY_W-1:0] delay_q [N_REQ];
    logic [DELAY_W-1:0] delay_d [N_REQ];
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   win;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [MAX_REQ-1:0] pend_ext;
    logic               grant;
    logic               cnt_last;

    always_comb begin
        pend_ext = '0;
        pend_ext[N_REQ-1:0] = pending_q;
    end

    assign grant = (state_q == IDLE) && (|pending_q);

`ifdef PULSE_STRETCH_SCHED_FIXED_PRIO_EN
    always_comb begin
        win = PTR_W'(fp_pick(pend_ext, N_REQ));
    end
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        win   = PTR_W'(rr_pick(pend_ext, int'(ptr_q), N_REQ));
        ptr_d = grant ? win : ptr_q;
    end

    // Reset pointer to the last index so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_W'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // A request is latched only when not already pending; the delay stays frozen until grant.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            delay_d[i] = delay_q[i];
            if (req_i[i] && !pending_q[i]) begin
                delay_d[i] = delay_i[i*DELAY_W +: DELAY_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req_i;
        owner_d   = owner_q;
        ack_d     = '0;
        done_d    = '0;
        gap_d     = gap_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d        = ACTIVE;
                    pending_d[win] = 1'b0;
                    owner_d        = win;
                    ack_d[win]     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_last) begin
                    state_d         = GAP;
                    done_d[owner_q] = 1'b1;
                    gap_d           = GAP_W'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            owner_q   <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            gap_q     <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            gap_q     <= gap_d;
            for (int i = 0; i < N_REQ; i++) begin
                delay_q[i] <= delay_d[i];
            end
        end
    end

    pulse_stretch_cnt #(
        .DELAY_W (DELAY_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (grant),
        .en_i    (state_q == ACTIVE),
        .delay_i (delay_q[win]),
        .last_o  (cnt_last)
    );

    assign pulse_out = (state_q == ACTIVE);
    assign busy_o    = (state_q != IDLE);
    assign ack_o     = ack_q;
    assign done_o    = done_q;
    assign owner_o   = owner_q;

endmodule

// File: tb/tb_pulse_stretch_sched.sv
// Directed bench for pulse_stretch_sched (N_REQ=4, DELAY_W=4, GAP_CYCLES=1)
// with per-cycle expected waveforms built from hand-computed pulse schedules.
module tb_pulse_stretch_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_i = '0;
    logic [15:0] delay_i = '0;
    logic [3:0]  ack_o;
    logic [3:0]  done_o;
    logic        pulse_out;
    logic        busy_o;
    logic [1:0]  owner_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0]  req_at   [64];
    logic [15:0] dly_at   [64];
    logic        rst_at   [64];
    logic        exp_pulse[64];
    logic        exp_busy [64];
    logic [3:0]  exp_ack  [64];
    logic [3:0]  exp_done [64];

    pulse_stretch_sched #(
        .N_REQ      (4),
        .DELAY_W    (4),
        .GAP_CYCLES (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .delay_i   (delay_i),
        .ack_o     (ack_o),
        .done_o    (done_o),
        .pulse_out (pulse_out),
        .busy_o    (busy_o),
        .owner_o   (owner_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dly(input int idx, input int d);
        logic [15:0] v;
        v = 16'(d & 15);
        return v << (idx * 4);
    endfunction

    task automatic clear_sched();
        for (int c = 0; c < 64; c++) begin
            req_at[c]    = '0;
            dly_at[c]    = '0;
            rst_at[c]    = 1'b0;
            exp_pulse[c] = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_ack[c]   = '0;
            exp_done[c]  = '0;
        end
    endtask

    // Pulse from cycle s for len cycles, done in the single GAP cycle after it.
    task automatic add_pulse(input int s, input int len, input int idx);
        for (int k = s; k < s + len; k++) begin
            exp_pulse[k] = 1'b1;
            exp_busy[k]  = 1'b1;
        end
        exp_ack[s]        = 4'(1 << idx);
        exp_done[s + len] = 4'(1 << idx);
        exp_busy[s + len] = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst     = 1'b1;
        req_i   = '0;
        delay_i = '0;
        repeat (2) @(negedge clk);
        chk({tag, ".rst.pulse"}, 32'(pulse_out), 0);
        chk({tag, ".rst.busy"},  32'(busy_o),    0);
        chk({tag, ".rst.ack"},   32'(ack_o),     0);
        chk({tag, ".rst.done"},  32'(done_o),    0);
        chk({tag, ".rst.owner"}, 32'(owner_o),   0);
        rst = 1'b0;
    endtask

    // Cycle c is observed at its falling edge, then that cycle's inputs are driven.
    task automatic run_sched(input string tag, input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            chk($sformatf("%s.c%0d.pulse", tag, c), 32'(pulse_out), 32'(exp_pulse[c]));
            chk($sformatf("%s.c%0d.busy", tag, c),  32'(busy_o),    32'(exp_busy[c]));
            chk($sformatf("%s.c%0d.ack", tag, c),   32'(ack_o),     32'(exp_ack[c]));
            chk($sformatf("%s.c%0d.done", tag, c),  32'(done_o),    32'(exp_done[c]));
            rst     = rst_at[c];
            req_i   = req_at[c];
            delay_i = dly_at[c];
        end
        rst     = 1'b0;
        req_i   = '0;
        delay_i = '0;
    endtask

    initial begin
        do_reset("single");
        clear_sched();
        req_at[0] = 4'b0010;
        dly_at[0] = dly(1, 12);
        add_pulse(2, 12, 1);
        run_sched("single", 18);
        chk("single.owner", 32'(owner_o), 1);

        do_reset("maxdly");
        clear_sched();
        req_at[0] = 4'b1000;
        dly_at[0] = dly(3, 15);
        add_pulse(2, 15, 3);
        run_sched("maxdly", 20);
        chk("maxdly.owner", 32'(owner_o), 3);

        do_reset("simul");
        clear_sched();
        req_at[0] = 4'b1011;
        dly_at[0] = dly(0, 3) | dly(1, 5) | dly(3, 2);
        add_pulse(2, 3, 0);
        add_pulse(7, 5, 1);
        add_pulse(14, 2, 3);
        run_sched("simul", 19);
        chk("simul.owner", 32'(owner_o), 3);

        do_reset("zero");
        clear_sched();
        req_at[0] = 4'b0100;
        dly_at[0] = dly(2, 0);
        add_pulse(2, 1, 2);
        run_sched("zero", 6);
        chk("zero.owner", 32'(owner_o), 2);

`ifndef PULSE_STRETCH_SCHED_FIXED_PRIO_EN
        do_reset("rereq");
        clear_sched();
        req_at[0] = 4'b0001;
        dly_at[0] = dly(0, 6);
        req_at[1] = 4'b0001;
        dly_at[1] = dly(0, 9);
        req_at[3] = 4'b1000;
        dly_at[3] = dly(3, 2);
        req_at[4] = 4'b0001;
        dly_at[4] = dly(0, 4);
        add_pulse(2, 6, 0);
        add_pulse(10, 2, 3);
        add_pulse(14, 4, 0);
        run_sched("rereq", 21);
        chk("rereq.owner", 32'(owner_o), 0);
`else
        do_reset("fprio");
        clear_sched();
        req_at[0] = 4'b1000;
        dly_at[0] = dly(3, 2);
        req_at[3] = 4'b1001;
        dly_at[3] = dly(0, 1) | dly(3, 1);
        req_at[6] = 4'b0001;
        dly_at[6] = dly(0, 1);
        add_pulse(2, 2, 3);
        add_pulse(6, 1, 0);
        add_pulse(9, 1, 0);
        add_pulse(12, 1, 3);
        run_sched("fprio", 16);
        chk("fprio.owner", 32'(owner_o), 3);
`endif

        do_reset("midrst");
        clear_sched();
        req_at[0] = 4'b0010;
        dly_at[0] = dly(1, 12);
        req_at[3] = 4'b0100;
        dly_at[3] = dly(2, 3);
        rst_at[6] = 1'b1;
        req_at[9] = 4'b0001;
        dly_at[9] = dly(0, 2);
        for (int k = 2; k <= 6; k++) begin
            exp_pulse[k] = 1'b1;
            exp_busy[k]  = 1'b1;
        end
        exp_ack[2] = 4'b0010;
        add_pulse(11, 2, 0);
        run_sched("midrst", 20);
        chk("midrst.owner", 32'(owner_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_stretch_sched.md
Name: pulse_stretch_sched

Overview:
- Scheduler that shares one pulse-stretch engine between N_REQ requesters.
- Each requester posts a request with its own stretch length. The block arbitrates round-robin, drives a single stretched pulse_out for the winner, then signals completion.
- Sits between several event sources and the single downstream stretched-pulse consumer.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DELAY_W, 4, width of each stretch-length field
- GAP_CYCLES, 1, idle guard cycles between consecutive pulses (minimum 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_i  in  N_REQ  per-requester request level, sampled every rising edge
- delay_i  in  N_REQ*DELAY_W  per-requester stretch length; slice i is [i*DELAY_W +: DELAY_W]
- ack_o  out  N_REQ  one-cycle pulse when requester i's pulse starts
- done_o  out  N_REQ  one-cycle pulse when requester i's pulse has ended
- pulse_out  out  1  shared stretched pulse
- busy_o  out  1  high in ACTIVE or GAP
- owner_o  out  $clog2(N_REQ)  index of the current or last owner

Behaviour:
Reset:
- pulse_out, busy_o, ack_o, done_o, owner_o, pending and captured delays all go to 0.
- RR pointer is set to N_REQ-1, so requester 0 wins first.

Capture:
- If req_i[i]=1 and pending[i]=0 at an edge, pending[i] is set and the delay_i slice is latched into delay_q[i].
- While pending[i]=1, further req_i[i] is ignored; the delay is not overwritten.
- pending[i] clears on grant. A requester may therefore re-request while its own pulse is active; it is served again in RR order.

FSM states (IDLE, ACTIVE, GAP):
- IDLE, any pending:
  - Winner = first pending index scanning from ptr+1 upward, with wrap.
  - Next edge: go to ACTIVE; load count = (delay_q==0 ? 1 : delay_q); clear pending[winner]; ptr = winner; owner_o = winner; ack_o[winner]=1 for that one cycle.
- ACTIVE:
  - pulse_out=1; count decrements each cycle.
  - Pulse length is exactly max(delay,1) cycles.
  - On the last cycle, next state is GAP.
- GAP:
  - pulse_out=0 for GAP_CYCLES cycles.
  - done_o[owner]=1 in the first GAP cycle only.
  - Then IDLE.

Latency:
- req_i high in cycle 0 → pending at edge 1 → pulse_out and ack_o high from cycle 2.
- Back-to-back grants: minimum spacing is GAP_CYCLES+1 low cycles between pulses (GAP plus one IDLE arbitration cycle).

Boundary conditions:
- delay 0 is treated as 1.
- Max delay 2^DELAY_W-1 gives no counter overflow.
- Simultaneous requests in one cycle are all captured and served in RR order from ptr+1.
- rst asserted mid-pulse: pulse_out drops at that edge; no done_o; all pending are lost.
- owner_o holds its value after GAP.

Optional Feature:
- Macro: PULSE_STRETCH_SCHED_FIXED_PRIO_EN
- Defined: fixed priority; lowest pending index always wins; ptr is unused.
- Undefined: round-robin as above.

Decomposition:
- Package pulse_stretch_pkg holds:
  - state enum sched_state_e {IDLE, ACTIVE, GAP}
  - DELAY_W default constant
  - function rr_pick(pending, ptr) returning the winner index
- Sub-module pulse_stretch_cnt:
  - load/count/last interface; loads max(delay,1), decrements, flags last cycle.
  - Keeps the counting logic out of the arbiter.

Test Plan:
- Single request: N_REQ=4, req_i[1] one cycle at cycle 0, delay 12 → ack_o[1] at cycle 2; pulse_out high cycles 2..13; done_o[1] at cycle 14; owner_o=1.
- Simultaneous requests: req_i=4'b1011 at cycle 0, delays 3,5,_,2 → pulses in order 0,1,3 with lengths 3,5,2; each separated by 2 low cycles (GAP_CYCLES=1).
- Zero delay: req_i[2] with delay 0 → pulse_out high exactly 1 cycle; done_o[2] next cycle.
- Re-request during own pulse: req_i[0] again mid-pulse while req_i[3] is pending → 3 is served before 0's second pulse.
- Reset mid-pulse: rst high at cycle 5 of a 12-cycle pulse → pulse_out=0 from that edge; no done_o; a later request to 0 succeeds first.
- Macro defined: req_i[3] pending, then req_i[0] and req_i[3] contend again → 0 always wins.
